bit_count_accumulator: RTL

Windowed accumulator sitting directly downstream of the bit population counter. Consumes its per-word count/valid stream, sums the counts of a fixed number of valid samples (one window), and presents the window total with a one-cycle valid pulse. Used to obtain bit density over a block of words, for example ones-density checks on a scrambled stream.

---
 rtl/bit_count_pkg.sv | 14 +
 rtl/bit_count_accumulator.sv | 115 +++++++++++
 2 files changed

// File: rtl/bit_count_pkg.sv
// Shared types and sizing helpers for the bit-count pipeline.
// Consumers of the window total size their inputs with sum_width().
package bit_count_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  function automatic int sum_width(input int cnt_width, input int window);
    return cnt_width + $clog2(window);
  endfunction

endpackage

// File: rtl/bit_count_accumulator.sv
// Sums the popcount of WINDOW valid samples and pulses sum_val_o with the total one cycle
// after the last sample; no backpressure. Optional threshold flag: BIT_COUNT_ACC_THRESH_EN.
module bit_count_accumulator
  import bit_count_pkg::*;
#(
  parameter int CNT_WIDTH = 3,
  parameter int WINDOW    = 16,
  parameter int SUM_W     = sum_width(CNT_WIDTH, WINDOW)
`ifdef BIT_COUNT_ACC_THRESH_EN
  , parameter int THRESHOLD = WINDOW * (2 ** (CNT_WIDTH - 1))
`endif
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic [CNT_WIDTH-1:0] cnt_i,
  input  logic                 cnt_val_i,
  input  logic                 clear_i,
  output logic [SUM_W-1:0]     sum_o,
  output logic                 sum_val_o,
  output logic                 busy_o
`ifdef BIT_COUNT_ACC_THRESH_EN
  , output logic               above_o
`endif
);

  localparam int IDX_W = $clog2(WINDOW);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);

  state_e           state_q, state_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             sum_val_q, sum_val_d;
  logic [SUM_W-1:0] total;

`ifdef BIT_COUNT_ACC_THRESH_EN
  localparam logic [SUM_W:0] THRESH_V = (SUM_W + 1)'(THRESHOLD);
  logic above_q, above_d;
`endif

  assign total = acc_q + SUM_W'(cnt_i);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    sum_val_d = 1'b0;
`ifdef BIT_COUNT_ACC_THRESH_EN
    above_d   = above_q;
`endif
    case (state_q)
      IDLE: begin
        if (cnt_val_i && !clear_i) begin
          acc_d   = SUM_W'(cnt_i);
          idx_d   = IDX_W'(1);
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (clear_i) begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = IDLE;
        end else if (cnt_val_i) begin
          if (idx_q == LAST_IDX) begin
            // Completing sample goes straight to the output so the next cycle can open a new window.
            sum_d     = total;
            sum_val_d = 1'b1;
            acc_d     = '0;
            idx_d     = '0;
            state_d   = IDLE;
`ifdef BIT_COUNT_ACC_THRESH_EN
            above_d   = ({1'b0, total} >= THRESH_V);
`endif
          end else begin
            acc_d = total;
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      idx_q     <= '0;
      sum_q     <= '0;
      sum_val_q <= 1'b0;
`ifdef BIT_COUNT_ACC_THRESH_EN
      above_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      sum_val_q <= sum_val_d;
`ifdef BIT_COUNT_ACC_THRESH_EN
      above_q   <= above_d;
`endif
    end
  end

  assign sum_o     = sum_q;
  assign sum_val_o = sum_val_q;
  assign busy_o    = (state_q == ACCUM);
`ifdef BIT_COUNT_ACC_THRESH_EN
  assign above_o   = above_q;
`endif

endmodule
